// File: rtl/ex_muldiv_control_pkg.sv
// ---------------------------------------------------------------------------
// ex_muldiv_control_pkg : shared EX-stage mul/div encodings (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package ex_muldiv_control_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_datapath.sv
// ---------------------------------------------------------------------------
// ex_muldiv_datapath : one shift-add / restoring-divide step plus sign fix (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module ex_muldiv_datapath
  import ex_muldiv_control_pkg::*;
(
  input  logic              is_div,
  input  logic [DATA_W-1:0] acc_hi,
  input  logic [DATA_W-1:0] acc_lo,
  input  logic [DATA_W-1:0] operand,
  input  logic              neg_main,
  input  logic              neg_rem,
  output logic [DATA_W-1:0] step_hi,
  output logic [DATA_W-1:0] step_lo,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic [2*DATA_W-1:0] product;
  logic [2*DATA_W-1:0] product_neg;

  // acc_hi:acc_lo is the running product (multiplier in the low half) or
  // remainder:quotient (dividend bits shift out of the top of acc_lo).
  always_comb begin
    mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    div_shift   = {acc_hi, acc_lo[DATA_W-1]};
    div_diff    = div_shift - {1'b0, operand};
    product     = {acc_hi, acc_lo};
    product_neg = -product;

    if (is_div) begin
      step_hi = div_diff[DATA_W] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
      step_lo = {acc_lo[DATA_W-2:0], ~div_diff[DATA_W]};
      res_hi  = neg_rem  ? -acc_hi : acc_hi;
      res_lo  = neg_main ? -acc_lo : acc_lo;
    end else begin
      {step_hi, step_lo} = {mul_sum, acc_lo[DATA_W-1:1]};
      {res_hi, res_lo}   = neg_main ? product_neg : product;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_control.sv
// ---------------------------------------------------------------------------
// ex_muldiv_control : iterative MULT/DIV sequencer owning HI/LO (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module ex_muldiv_control
  import ex_muldiv_control_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start_EX,
  input  logic [1:0]        Op_EX,
  input  logic [DATA_W-1:0] Rs_Data_EX,
  input  logic [DATA_W-1:0] Rt_Data_EX,
  input  logic              Read_HiLo_EX,
  input  logic              Write_HI_EX,
  input  logic              Write_LO_EX,
  output logic              Busy_EX,
  output logic              Stall_EX,
  output logic              Done_EX,
  output logic              Div_By_Zero_EX,
  output logic [DATA_W-1:0] HI_EX,
  output logic [DATA_W-1:0] LO_EX
);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] acc_hi, acc_lo, operand;
  logic              is_div, neg_main, neg_rem, div_zero;
  logic [DATA_W-1:0] step_hi, step_lo, res_hi, res_lo;
  logic              op_signed, rt_zero;

  assign op_signed = ~Op_EX[0];
  assign rt_zero   = (Rt_Data_EX == '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (Start_EX) begin
        if (Op_EX[1] && rt_zero) state_nxt = ST_DONE;
        else if (Op_EX[1])       state_nxt = ST_DIV;
        else                     state_nxt = ST_MUL;
      end
      ST_MUL, ST_DIV: if (count == '0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy_EX        = (state != ST_IDLE);
    Done_EX        = (state == ST_DONE);
    Div_By_Zero_EX = (state == ST_DONE) && div_zero;
    Stall_EX       = Busy_EX && (Start_EX || Read_HiLo_EX || Write_HI_EX || Write_LO_EX);
  end

  // Operands are latched as magnitudes; the recorded signs are applied in FIX,
  // whose corrected result is committed to HI/LO on the edge into DONE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      HI_EX    <= '0;
      LO_EX    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Write_HI_EX) HI_EX <= Rs_Data_EX;
          if (Write_LO_EX) LO_EX <= Rs_Data_EX;
          if (Start_EX) begin
            is_div   <= Op_EX[1];
            operand  <= magnitude(Rt_Data_EX, op_signed);
            acc_lo   <= magnitude(Rs_Data_EX, op_signed);
            acc_hi   <= '0;
            count    <= CNT_W'(ITER_COUNT);
            neg_main <= op_signed && (Rs_Data_EX[DATA_W-1] ^ Rt_Data_EX[DATA_W-1]);
            neg_rem  <= op_signed && Op_EX[1] && Rs_Data_EX[DATA_W-1];
            div_zero <= Op_EX[1] && rt_zero;
          end
        end
        ST_MUL, ST_DIV: begin
          if (count != '0) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count - CNT_W'(1);
          end
        end
        ST_FIX: begin
          HI_EX <= res_hi;
          LO_EX <= res_lo;
        end
        default: ;
      endcase
    end
  end

  ex_muldiv_datapath u_datapath (
    .is_div   (is_div),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .operand  (operand),
    .neg_main (neg_main),
    .neg_rem  (neg_rem),
    .step_hi  (step_hi),
    .step_lo  (step_lo),
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

endmodule

`default_nettype wire

// File: doc/ex_muldiv_control.md
EX_MULDIV_CONTROL -- requirements
Module: ex_muldiv_control

Interface
REQ-001 DATA_W, 32, operand and HI/LO width; only 32 is supported.
REQ-002 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start_EX  input  1  request to begin a multiply/divide this cycle.
REQ-005 Op_EX  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Rs_Data_EX  input  32  multiplicand or dividend.
REQ-007 Rt_Data_EX  input  32  multiplier or divisor.
REQ-008 Read_HiLo_EX  input  1  an EX-stage instruction (MFHI/MFLO) needs HI/LO this cycle.
REQ-009 Write_HI_EX / Write_LO_EX  input  1 each  MTHI/MTLO request; data taken from Rs_Data_EX.
REQ-010 Busy_EX  output  1  high while an operation is in progress.
REQ-011 Stall_EX  output  1  combinational pipeline-freeze request.
REQ-012 Done_EX  output  1  one-cycle pulse when HI/LO take a new result.
REQ-013 Div_By_Zero_EX  output  1  one-cycle pulse alongside Done_EX for a zero divisor.
REQ-014 HI_EX / LO_EX  output  32 each  architectural HI and LO registers.

Function
REQ-015 FSM states: IDLE, MUL, DIV, FIX, DONE; FSM leaves IDLE only on Start_EX.
REQ-016 Start_EX in IDLE latches the operands and Op_EX, loads a 6-bit count with 32, and goes to MUL (Op_EX[1]=0) or DIV (Op_EX[1]=1).
REQ-017 Signed ops (MULT/DIV) convert the operands to magnitudes at latch time and record the result signs.
REQ-018 MUL runs unsigned shift-add, one bit per cycle, for 32 cycles, then goes to FIX.
REQ-019 DIV runs restoring division, one quotient bit per cycle, for 32 cycles, then goes to FIX.
REQ-020 FIX negates the product (MULT) or the quotient and remainder (DIV) as the recorded signs require.
REQ-021 Sign rules: quotient truncates toward zero; remainder takes the dividend's sign.
REQ-022 FIX then goes to DONE.
REQ-023 DONE writes the results and asserts Done_EX for that cycle: HI=product[63:32], LO=product[31:0] for multiply; LO=quotient, HI=remainder for divide.
REQ-024 DONE returns to IDLE on the next edge.
REQ-025 Latency: Start_EX at edge N gives Done_EX high during the cycle after edge N+34; HI/LO are valid from edge N+34.
REQ-026 Divisor zero: DIV is skipped and the FSM goes directly to DONE; HI/LO stay unchanged; Div_By_Zero_EX pulses with Done_EX.
REQ-027 DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no flag).
REQ-028 Busy_EX is high in MUL, DIV, FIX and DONE.
REQ-029 Stall_EX = Busy_EX AND (Start_EX OR Read_HiLo_EX OR Write_HI_EX OR Write_LO_EX).
REQ-030 Start_EX while Busy_EX is ignored; the stalled pipeline re-presents it.
REQ-031 Write_HI_EX / Write_LO_EX in IDLE update the register at the next edge.
REQ-032 If Start_EX and a write are both present in IDLE, the write is applied and the operation also starts.
REQ-033 Read_HiLo_EX in IDLE or in the DONE cycle's successor returns the current register value; it never stalls in IDLE.

Reset
REQ-034 Reset forces IDLE, count=0, HI_EX=LO_EX=0, Busy_EX=Done_EX=Div_By_Zero_EX=0, at any time including mid-operation.
REQ-035 An operation interrupted by Reset is discarded with no HI/LO update.

Structure
REQ-036 The following belong in the shared EX package: the Op_EX encodings, the state encoding, and ITER_COUNT=32.
REQ-037 A single sub-module, ex_muldiv_datapath (shift-add/restoring-divide step and sign fix), is instantiated under the FSM.

Verification
REQ-038 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 34 edges HI=0xFFFFFFFE, LO=0x00000001, one Done_EX pulse.
REQ-039 MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-040 DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2.
REQ-041 DIVU x / 0 with HI=0x11, LO=0x22 -> HI/LO unchanged, Div_By_Zero_EX and Done_EX pulse together, FSM back to IDLE.
REQ-042 Read_HiLo_EX held during a MULT -> Stall_EX high until the DONE cycle ends, low in IDLE; a second Start_EX while busy is ignored.
REQ-043 Reset asserted at iteration 10 -> immediate IDLE, HI=LO=0, no Done_EX.
